axis_out_pkt_fifo: RTL

// Output-side buffer directly downstream of dnn_engine's m_axis port, feeding the output DMA.

---
 rtl/axis_out_pkt_fifo.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/axis_out_pkt_fifo.sv
// axis_out_pkt_fifo
// First-word-fall-through packet buffer placed between the DNN engine's
// master stream and the output DMA. It stores {tdata, tkeep, tlast, tuser}
// beats so that engine stalls and DMA backpressure do not couple. It also
// counts the bytes and packets that are actually handed to the DMA.
//
// Ports
//   aclk, aresetn     clock (rising edge) and asynchronous active-low reset
//   s_axis_*          upstream beat input (tready/tvalid/tlast/tdata/tkeep/tuser)
//   m_axis_*          downstream beat output, driven from the head entry (FWFT)
//   level             current occupancy, 0..DEPTH
//   pkt_bytes         byte total of the last completed output packet
//   pkt_count         packets completed on the output since reset (wraps)
//   pkt_done          one-cycle pulse when pkt_bytes/pkt_count have just updated
module axis_out_pkt_fifo #(
  parameter int DATA_WIDTH = 128,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int USER_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int CNT_BITS   = 32
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  output logic                    s_axis_tready,
  input  logic                    s_axis_tvalid,
  input  logic                    s_axis_tlast,
  input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0]   s_axis_tkeep,
  input  logic [USER_WIDTH-1:0]   s_axis_tuser,
  input  logic                    m_axis_tready,
  output logic                    m_axis_tvalid,
  output logic                    m_axis_tlast,
  output logic [DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]   m_axis_tkeep,
  output logic [USER_WIDTH-1:0]   m_axis_tuser,
  output logic [$clog2(DEPTH):0]  level,
  output logic [CNT_BITS-1:0]     pkt_bytes,
  output logic [CNT_BITS-1:0]     pkt_count,
  output logic                    pkt_done
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int LVL_W   = PTR_W + 1;
  localparam int ENTRY_W = DATA_WIDTH + KEEP_WIDTH + 1 + USER_WIDTH;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  // Number of set bits in a keep vector, zero-extended to the counter width.
  function automatic logic [CNT_BITS-1:0] keep_popcount(input logic [KEEP_WIDTH-1:0] keep);
    logic [CNT_BITS-1:0] cnt;
    cnt = {CNT_BITS{1'b0}};
    for (int i = 0; i < KEEP_WIDTH; i++) begin
      cnt = cnt + {{(CNT_BITS-1){1'b0}}, keep[i]};
    end
    return cnt;
  endfunction

  logic [ENTRY_W-1:0]  mem_q [DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]    level_q, level_d;
  logic                rdy_en_q;
  logic [CNT_BITS-1:0] run_sum_q, run_sum_d;
  logic [CNT_BITS-1:0] pkt_bytes_q, pkt_bytes_d;
  logic [CNT_BITS-1:0] pkt_count_q, pkt_count_d;
  logic                pkt_done_q, pkt_done_d;

  logic                push;
  logic                pop;
  logic                full;
  logic [CNT_BITS-1:0] beat_bytes;

  // Ready depends only on flops, so there is no m_axis_tready -> s_axis_tready path;
  // a full buffer refuses input even in a cycle where it is also popping.
  assign full          = (level_q == FULL_LVL);
  assign s_axis_tready = rdy_en_q & ~full;
  assign m_axis_tvalid = (level_q != {LVL_W{1'b0}});
  assign push          = s_axis_tvalid & s_axis_tready;
  assign pop           = m_axis_tvalid & m_axis_tready;

  assign {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser} = mem_q[rd_ptr_q];
  assign beat_bytes    = keep_popcount(m_axis_tkeep);

  assign level     = level_q;
  assign pkt_bytes = pkt_bytes_q;
  assign pkt_count = pkt_count_q;
  assign pkt_done  = pkt_done_q;

  // Storage write; the array is deliberately not reset.
  always_ff @(posedge aclk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {s_axis_tdata, s_axis_tkeep, s_axis_tlast, s_axis_tuser};
    end
  end

  // Next-state for pointers, occupancy and packet accounting.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    run_sum_d   = run_sum_q;
    pkt_bytes_d = pkt_bytes_q;
    pkt_count_d = pkt_count_q;
    pkt_done_d  = 1'b0;

    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase

    // Bytes are counted only when a beat actually leaves towards the DMA.
    if (pop) begin
      if (m_axis_tlast) begin
        pkt_bytes_d = run_sum_q + beat_bytes;
        run_sum_d   = {CNT_BITS{1'b0}};
        pkt_count_d = pkt_count_q + CNT_BITS'(1);
        pkt_done_d  = 1'b1;
      end else begin
        run_sum_d   = run_sum_q + beat_bytes;
      end
    end else begin
      pkt_done_d = 1'b0;
    end
  end

  // State registers; reset discards buffered beats and any partial packet sum.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rdy_en_q    <= 1'b0;
      wr_ptr_q    <= {PTR_W{1'b0}};
      rd_ptr_q    <= {PTR_W{1'b0}};
      level_q     <= {LVL_W{1'b0}};
      run_sum_q   <= {CNT_BITS{1'b0}};
      pkt_bytes_q <= {CNT_BITS{1'b0}};
      pkt_count_q <= {CNT_BITS{1'b0}};
      pkt_done_q  <= 1'b0;
    end else begin
      rdy_en_q    <= 1'b1;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      run_sum_q   <= run_sum_d;
      pkt_bytes_q <= pkt_bytes_d;
      pkt_count_q <= pkt_count_d;
      pkt_done_q  <= pkt_done_d;
    end
  end

endmodule
